// File: rtl/bank_timing_tracker_pkg.sv
// Shared command/status encodings and default DRAM timing values for the
// per-bank timing tracker.
package bank_timing_tracker_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACTIVE,
    CMD_READ,
    CMD_WRITE,
    CMD_PRECHARGE,
    CMD_REFRESH,
    CMD_POWER_D,
    CMD_POWER_U
  } sch_cmd_t;

  typedef enum logic [2:0] {
    CODE_IDLE,
    CODE_ACTIVE_TO_READ_WRITE,
    CODE_WRITE_TO_PRECHARGE,
    CODE_READ_TO_PRECHARGE,
    CODE_PRECHARGE_TO_ACTIVE
  } recode_state_t;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_PRE,
    TAG_READ,
    TAG_WRITE
  } bank_tag_t;

  localparam int unsigned DEF_NUM_BANKS = 8;
  localparam int unsigned DEF_CNT_W     = 8;
  localparam int unsigned DEF_T_RCD     = 4;
  localparam int unsigned DEF_T_RP      = 4;
  localparam int unsigned DEF_T_RAS     = 10;
  localparam int unsigned DEF_T_RC      = 14;
  localparam int unsigned DEF_T_WR      = 12;
  localparam int unsigned DEF_T_RTP     = 3;
  localparam int unsigned DEF_T_RRD     = 2;
  localparam int unsigned DEF_T_CCD     = 4;
  localparam int unsigned DEF_T_RFC     = 20;

  // Saturating decrement, optionally raised to t_x-1 so a shorter constraint
  // never shortens a pending longer one.
  function automatic int unsigned cnt_next(int unsigned cur, int unsigned t_x, logic load);
    int unsigned dec = (cur == 0) ? 0 : cur - 1;
    int unsigned ld  = (t_x == 0) ? 0 : t_x - 1;
    return (load && (ld > dec)) ? ld : dec;
  endfunction

endpackage

// File: rtl/bank_timing_tracker_if.sv
// Command-issue and legality-status bundle between the scheduler and the tracker.
interface bank_timing_tracker_if
  import bank_timing_tracker_pkg::*;
#(
  parameter int unsigned NUM_BANKS = DEF_NUM_BANKS,
  parameter int unsigned BA_W      = $clog2(NUM_BANKS)
);
  logic                            issue_valid;
  sch_cmd_t                        issue_cmd;
  logic [BA_W-1:0]                 issue_bank;
  logic [NUM_BANKS-1:0]            act_ok;
  logic [NUM_BANKS-1:0]            rw_ok;
  logic [NUM_BANKS-1:0]            pre_ok;
  logic                            ref_ok;
  logic [NUM_BANKS-1:0]            row_open;
  recode_state_t [NUM_BANKS-1:0]   bank_code;
  logic                            err_illegal;

  modport master (
    output issue_valid, issue_cmd, issue_bank,
    input  act_ok, rw_ok, pre_ok, ref_ok, row_open, bank_code, err_illegal
  );

  modport slave (
    input  issue_valid, issue_cmd, issue_bank,
    output act_ok, rw_ok, pre_ok, ref_ok, row_open, bank_code, err_illegal
  );
endinterface

// File: rtl/bank_timing_tracker_slice.sv
// One bank's tRC/tRP, tRCD and tRAS/tRTP/tWR countdowns, open-row flag and
// blocking-constraint code.
module bank_timing_slice
  import bank_timing_tracker_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned T_RCD = DEF_T_RCD,
  parameter int unsigned T_RP  = DEF_T_RP,
  parameter int unsigned T_RAS = DEF_T_RAS,
  parameter int unsigned T_RC  = DEF_T_RC,
  parameter int unsigned T_WR  = DEF_T_WR,
  parameter int unsigned T_RTP = DEF_T_RTP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_act,
  input  logic          i_rd,
  input  logic          i_wr,
  input  logic          i_pre,
  input  logic          i_act_gate,
  input  logic          i_rw_gate,
  output logic          o_row_open,
  output logic          o_act_ok,
  output logic          o_rw_ok,
  output logic          o_pre_ok,
  output logic          o_act_idle,
  output recode_state_t o_code
);
  logic [CNT_W-1:0] r_act_cnt;
  logic [CNT_W-1:0] r_rcd_cnt;
  logic [CNT_W-1:0] r_pre_cnt;
  logic             r_row_open;
  bank_tag_t        r_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_cnt  <= '0;
      r_rcd_cnt  <= '0;
      r_pre_cnt  <= '0;
      r_row_open <= 1'b0;
      r_tag      <= TAG_NONE;
    end else begin
      r_act_cnt <= CNT_W'(cnt_next(32'(r_act_cnt), i_pre ? T_RP : T_RC, i_pre | i_act));
      r_rcd_cnt <= CNT_W'(cnt_next(32'(r_rcd_cnt), T_RCD, i_act));
      r_pre_cnt <= CNT_W'(cnt_next(32'(r_pre_cnt),
                                   i_act ? T_RAS : (i_wr ? T_WR : T_RTP),
                                   i_act | i_rd | i_wr));
      if (i_act)      r_row_open <= 1'b1;
      else if (i_pre) r_row_open <= 1'b0;
      if (i_act)      r_tag <= TAG_NONE;
      else if (i_pre) r_tag <= TAG_PRE;
      else if (i_rd)  r_tag <= TAG_READ;
      else if (i_wr)  r_tag <= TAG_WRITE;
    end
  end

  assign o_row_open = r_row_open;
  assign o_act_idle = (r_act_cnt == '0);
  assign o_act_ok   = !r_row_open && o_act_idle && i_act_gate;
  assign o_rw_ok    = r_row_open && (r_rcd_cnt == '0) && i_rw_gate;
  assign o_pre_ok   = r_row_open && (r_pre_cnt == '0);

  always_comb begin
    o_code = CODE_IDLE;
    if (r_rcd_cnt != '0)                             o_code = CODE_ACTIVE_TO_READ_WRITE;
    else if ((r_pre_cnt != '0) && (r_tag == TAG_WRITE)) o_code = CODE_WRITE_TO_PRECHARGE;
    else if ((r_pre_cnt != '0) && (r_tag == TAG_READ))  o_code = CODE_READ_TO_PRECHARGE;
    else if ((r_act_cnt != '0) && (r_tag == TAG_PRE))   o_code = CODE_PRECHARGE_TO_ACTIVE;
  end
endmodule

// File: rtl/bank_timing_tracker.sv
// Per-bank DRAM timing tracker: NUM_BANKS bank slices plus the global
// tRRD, tCCD and tRFC countdowns and the illegal-issue detector.
module bank_timing_tracker
  import bank_timing_tracker_pkg::*;
#(
  parameter int unsigned NUM_BANKS = DEF_NUM_BANKS,
  parameter int unsigned BA_W      = $clog2(NUM_BANKS),
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned T_RCD     = DEF_T_RCD,
  parameter int unsigned T_RP      = DEF_T_RP,
  parameter int unsigned T_RAS     = DEF_T_RAS,
  parameter int unsigned T_RC      = DEF_T_RC,
  parameter int unsigned T_WR      = DEF_T_WR,
  parameter int unsigned T_RTP     = DEF_T_RTP,
  parameter int unsigned T_RRD     = DEF_T_RRD,
  parameter int unsigned T_CCD     = DEF_T_CCD,
  parameter int unsigned T_RFC     = DEF_T_RFC
) (
  input  logic                  clk,
  input  logic                  rst,
  bank_timing_tracker_if.slave  bus
);
  logic [CNT_W-1:0]              r_rrd_cnt;
  logic [CNT_W-1:0]              r_ccd_cnt;
  logic [CNT_W-1:0]              r_rfc_cnt;
  logic                          r_err;
  logic [BA_W-1:0]               w_bank;
  logic                          w_legal;
  logic                          w_do;
  logic                          w_ref_ok;
  logic [NUM_BANKS-1:0]          w_act_ok;
  logic [NUM_BANKS-1:0]          w_rw_ok;
  logic [NUM_BANKS-1:0]          w_pre_ok;
  logic [NUM_BANKS-1:0]          w_row_open;
  logic [NUM_BANKS-1:0]          w_act_idle;
  recode_state_t [NUM_BANKS-1:0] w_code;

  assign w_bank   = bus.issue_bank;
  assign w_ref_ok = ~|w_row_open && &w_act_idle && (r_rfc_cnt == '0);

  always_comb begin
    w_legal = 1'b1;
    case (bus.issue_cmd)
      CMD_ACTIVE:          w_legal = w_act_ok[w_bank];
      CMD_READ, CMD_WRITE: w_legal = w_rw_ok[w_bank];
      CMD_PRECHARGE:       w_legal = w_pre_ok[w_bank];
      CMD_REFRESH:         w_legal = w_ref_ok;
      default:             w_legal = 1'b1;
    endcase
  end

  // Illegal commands are reported but leave every counter untouched.
  assign w_do = bus.issue_valid && w_legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rrd_cnt <= '0;
      r_ccd_cnt <= '0;
      r_rfc_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_rrd_cnt <= CNT_W'(cnt_next(32'(r_rrd_cnt), T_RRD, w_do && (bus.issue_cmd == CMD_ACTIVE)));
      r_ccd_cnt <= CNT_W'(cnt_next(32'(r_ccd_cnt), T_CCD,
                   w_do && ((bus.issue_cmd == CMD_READ) || (bus.issue_cmd == CMD_WRITE))));
      r_rfc_cnt <= CNT_W'(cnt_next(32'(r_rfc_cnt), T_RFC, w_do && (bus.issue_cmd == CMD_REFRESH)));
      r_err     <= bus.issue_valid && !w_legal;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic w_sel;
    assign w_sel = w_do && (w_bank == BA_W'(g));

    bank_timing_slice #(
      .CNT_W (CNT_W),
      .T_RCD (T_RCD),
      .T_RP  (T_RP),
      .T_RAS (T_RAS),
      .T_RC  (T_RC),
      .T_WR  (T_WR),
      .T_RTP (T_RTP)
    ) u_slice (
      .clk        (clk),
      .rst        (rst),
      .i_act      (w_sel && (bus.issue_cmd == CMD_ACTIVE)),
      .i_rd       (w_sel && (bus.issue_cmd == CMD_READ)),
      .i_wr       (w_sel && (bus.issue_cmd == CMD_WRITE)),
      .i_pre      (w_sel && (bus.issue_cmd == CMD_PRECHARGE)),
      .i_act_gate ((r_rrd_cnt == '0) && (r_rfc_cnt == '0)),
      .i_rw_gate  (r_ccd_cnt == '0),
      .o_row_open (w_row_open[g]),
      .o_act_ok   (w_act_ok[g]),
      .o_rw_ok    (w_rw_ok[g]),
      .o_pre_ok   (w_pre_ok[g]),
      .o_act_idle (w_act_idle[g]),
      .o_code     (w_code[g])
    );
  end

  assign bus.act_ok      = w_act_ok;
  assign bus.rw_ok       = w_rw_ok;
  assign bus.pre_ok      = w_pre_ok;
  assign bus.ref_ok      = w_ref_ok;
  assign bus.row_open    = w_row_open;
  assign bus.bank_code   = w_code;
  assign bus.err_illegal = r_err;
endmodule

// File: tb/tb_bank_timing_tracker.sv
// Scoreboard bench: a timestamp-based reference model predicts each cycle's
// outputs; a negedge monitor pops and compares them against the tracker.
module tb_bank_timing_tracker;
  import bank_timing_tracker_pkg::*;

  localparam int NB    = 8;
  localparam int BW    = 3;
  localparam int T_RCD = 4;
  localparam int T_RP  = 4;
  localparam int T_RAS = 10;
  localparam int T_RC  = 14;
  localparam int T_WR  = 12;
  localparam int T_RTP = 3;
  localparam int T_RRD = 2;
  localparam int T_CCD = 4;
  localparam int T_RFC = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bank_timing_tracker_if #(.NUM_BANKS(NB)) bus ();

  bank_timing_tracker #(
    .NUM_BANKS (NB),
    .CNT_W     (8),
    .T_RCD     (T_RCD),
    .T_RP      (T_RP),
    .T_RAS     (T_RAS),
    .T_RC      (T_RC),
    .T_WR      (T_WR),
    .T_RTP     (T_RTP),
    .T_RRD     (T_RRD),
    .T_CCD     (T_CCD),
    .T_RFC     (T_RFC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [NB-1:0]   act;
    logic [NB-1:0]   rw;
    logic [NB-1:0]   pre;
    logic [NB-1:0]   open;
    logic            refok;
    logic [3*NB-1:0] code;
    logic            err;
    int              cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: absolute cycle from which each command becomes legal.
  int        cyc;
  int        act_rdy[NB];
  int        rcd_rdy[NB];
  int        pre_rdy[NB];
  bit        open_m[NB];
  bank_tag_t tag_m[NB];
  int        rrd_rdy, ccd_rdy, rfc_rdy;
  bit        err_m;

  function automatic int mx(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < NB; b++) begin
      act_rdy[b] = 0; rcd_rdy[b] = 0; pre_rdy[b] = 0;
      open_m[b] = 1'b0; tag_m[b] = TAG_NONE;
    end
    rrd_rdy = 0; ccd_rdy = 0; rfc_rdy = 0; err_m = 1'b0;
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    bit any_open = 1'b0;
    bit all_free = 1'b1;
    recode_state_t c;
    e.cyc = cyc;
    e.err = err_m;
    for (int b = 0; b < NB; b++) begin
      e.open[b] = open_m[b];
      e.act[b]  = !open_m[b] && cyc >= act_rdy[b] && cyc >= rrd_rdy && cyc >= rfc_rdy;
      e.rw[b]   = open_m[b] && cyc >= rcd_rdy[b] && cyc >= ccd_rdy;
      e.pre[b]  = open_m[b] && cyc >= pre_rdy[b];
      any_open |= open_m[b];
      all_free &= (cyc >= act_rdy[b]);
      if (cyc < rcd_rdy[b])                               c = CODE_ACTIVE_TO_READ_WRITE;
      else if (cyc < pre_rdy[b] && tag_m[b] == TAG_WRITE) c = CODE_WRITE_TO_PRECHARGE;
      else if (cyc < pre_rdy[b] && tag_m[b] == TAG_READ)  c = CODE_READ_TO_PRECHARGE;
      else if (cyc < act_rdy[b] && tag_m[b] == TAG_PRE)   c = CODE_PRECHARGE_TO_ACTIVE;
      else                                                c = CODE_IDLE;
      e.code[b*3 +: 3] = c;
    end
    e.refok = !any_open && all_free && cyc >= rfc_rdy;
    return e;
  endfunction

  task automatic step(bit r, bit v, sch_cmd_t c, int b);
    exp_t e;
    bit   ok;
    e = expect_now();
    sbq.push_back(e);
    rst             = r;
    bus.issue_valid = v;
    bus.issue_cmd   = c;
    bus.issue_bank  = BW'(b);
    case (c)
      CMD_ACTIVE:          ok = e.act[b];
      CMD_READ, CMD_WRITE: ok = e.rw[b];
      CMD_PRECHARGE:       ok = e.pre[b];
      CMD_REFRESH:         ok = e.refok;
      default:             ok = 1'b1;
    endcase
    if (r) begin
      model_clear();
    end else begin
      err_m = v && !ok;
      if (v && ok) begin
        case (c)
          CMD_ACTIVE: begin
            open_m[b] = 1'b1; tag_m[b] = TAG_NONE;
            act_rdy[b] = mx(act_rdy[b], cyc + T_RC);
            rcd_rdy[b] = mx(rcd_rdy[b], cyc + T_RCD);
            pre_rdy[b] = mx(pre_rdy[b], cyc + T_RAS);
            rrd_rdy    = mx(rrd_rdy, cyc + T_RRD);
          end
          CMD_READ: begin
            tag_m[b] = TAG_READ;
            pre_rdy[b] = mx(pre_rdy[b], cyc + T_RTP);
            ccd_rdy    = mx(ccd_rdy, cyc + T_CCD);
          end
          CMD_WRITE: begin
            tag_m[b] = TAG_WRITE;
            pre_rdy[b] = mx(pre_rdy[b], cyc + T_WR);
            ccd_rdy    = mx(ccd_rdy, cyc + T_CCD);
          end
          CMD_PRECHARGE: begin
            open_m[b] = 1'b0; tag_m[b] = TAG_PRE;
            act_rdy[b] = mx(act_rdy[b], cyc + T_RP);
          end
          CMD_REFRESH: rfc_rdy = mx(rfc_rdy, cyc + T_RFC);
          default: ;
        endcase
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic nops(int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, CMD_NOP, 0);
  endtask

  task automatic cmd(sch_cmd_t c, int b);
    step(1'b0, 1'b1, c, b);
  endtask

  task automatic chk(string nm, int c, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("act_ok",      e.cyc, 64'(bus.act_ok),      64'(e.act));
      chk("rw_ok",       e.cyc, 64'(bus.rw_ok),       64'(e.rw));
      chk("pre_ok",      e.cyc, 64'(bus.pre_ok),      64'(e.pre));
      chk("ref_ok",      e.cyc, 64'(bus.ref_ok),      64'(e.refok));
      chk("row_open",    e.cyc, 64'(bus.row_open),    64'(e.open));
      chk("bank_code",   e.cyc, 64'(bus.bank_code),   64'(e.code));
      chk("err_illegal", e.cyc, 64'(bus.err_illegal), 64'(e.err));
    end
  end

  initial begin
    int r;
    int w;
    sch_cmd_t c;
    rst             = 1'b1;
    bus.issue_valid = 1'b0;
    bus.issue_cmd   = CMD_NOP;
    bus.issue_bank  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    cyc = 0;

    nops(1);
    cmd(CMD_ACTIVE, 3); nops(12);
    step(1'b1, 1'b0, CMD_NOP, 0);
    cmd(CMD_ACTIVE, 0); nops(3); cmd(CMD_WRITE, 0); nops(13); cmd(CMD_PRECHARGE, 0);
    cmd(CMD_ACTIVE, 1); nops(3); cmd(CMD_READ, 1); nops(5); cmd(CMD_PRECHARGE, 1); nops(5);
    cmd(CMD_ACTIVE, 2); nops(1); cmd(CMD_ACTIVE, 4); nops(4);
    cmd(CMD_READ, 2); nops(1); cmd(CMD_READ, 4); nops(1); cmd(CMD_READ, 4); nops(2);
    cmd(CMD_PRECHARGE, 3); cmd(CMD_REFRESH, 0);
    step(1'b1, 1'b0, CMD_NOP, 0);
    cmd(CMD_REFRESH, 0); cmd(CMD_ACTIVE, 5); nops(19); cmd(CMD_REFRESH, 0); cmd(CMD_ACTIVE, 5);
    nops(3);
    cmd(CMD_ACTIVE, 6); nops(2); step(1'b1, 1'b1, CMD_ACTIVE, 7); nops(2);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      w = $urandom_range(0, 99);
      if (w < 30)      c = CMD_ACTIVE;
      else if (w < 50) c = CMD_READ;
      else if (w < 65) c = CMD_WRITE;
      else if (w < 82) c = CMD_PRECHARGE;
      else if (w < 86) c = CMD_REFRESH;
      else if (w < 94) c = CMD_NOP;
      else if (w < 97) c = CMD_POWER_D;
      else             c = CMD_POWER_U;
      step(r == 0, $urandom_range(0, 9) != 0, c, $urandom_range(0, NB - 1));
    end
    bus.issue_valid = 1'b0;
    for (int i = 0; i < 4 && sbq.size() != 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drain", cyc, 64'(sbq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
